// File: rtl/iserdes_word_aligner.sv
// iserdes_word_aligner: per-lane BITSLIP word alignment of ISERDESE2 outputs against PATTERN.
// Optional LOCK_MONITOR_EN: while train is high, persistent mismatches drop lock and realign.
module iserdes_word_aligner #(
   parameter int unsigned       WIDTH       = 8,
   parameter int unsigned       CHANNELS    = 4,
   parameter logic [WIDTH-1:0]  PATTERN     = 8'h3C,
   parameter int unsigned       MATCH_COUNT = 4,
   parameter int unsigned       SETTLE      = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      align_start,
   input  logic                      train,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   output logic [CHANNELS-1:0]       bitslip,
   output logic [CHANNELS-1:0]       locked,
   output logic [CHANNELS-1:0]       align_err,
   output logic                      align_done,
   output logic [CHANNELS*WIDTH-1:0] data_out,
   output logic                      data_valid
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CHECK  = 3'd1;
   localparam logic [2:0] ST_SLIP   = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_LOCKED = 3'd4;
   localparam logic [2:0] ST_FAIL   = 3'd5;

   localparam logic [3:0] MATCH_LAST  = 4'(MATCH_COUNT);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [2:0] SLIP_LAST   = 3'(WIDTH - 1);
`ifdef LOCK_MONITOR_EN
   localparam logic [3:0] MISS_LAST   = 4'(MATCH_COUNT - 1);
`else
   logic unused_train;
   assign unused_train = train;
`endif

   logic [CHANNELS-1:0] lock_nx;
   logic [CHANNELS-1:0] err_nx;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [2:0]       state_q, state_d;
      logic [3:0]       match_q, match_d;
      logic [2:0]       slip_cnt_q, slip_cnt_d;
      logic [3:0]       settle_q, settle_d;
      logic             slip_q, slip_d;
      logic             lock_q, lock_d;
      logic             err_q, err_d;
      logic [WIDTH-1:0] word;
      logic             hit;

      assign word = data_in[c*WIDTH +: WIDTH];
      assign hit  = (word == PATTERN);

      always_comb begin
         state_d    = state_q;
         match_d    = match_q;
         slip_cnt_d = slip_cnt_q;
         settle_d   = settle_q;
         slip_d     = 1'b0;
         lock_d     = lock_q;
         err_d      = err_q;
         if (align_start) begin
            // A BITSLIP pulse already in flight ends on its own; slip_d stays low.
            state_d    = ST_CHECK;
            match_d    = '0;
            slip_cnt_d = '0;
            settle_d   = '0;
            lock_d     = 1'b0;
            err_d      = 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: ;
               ST_CHECK: begin
                  if (hit) begin
                     match_d = match_q + 4'd1;
                     if (match_d == MATCH_LAST) begin
                        state_d = ST_LOCKED;
                        lock_d  = 1'b1;
                        match_d = '0;
                     end
                  end else if (slip_cnt_q == SLIP_LAST) begin
                     state_d = ST_FAIL;
                     err_d   = 1'b1;
                     match_d = '0;
                  end else begin
                     state_d = ST_SLIP;
                     slip_d  = 1'b1;
                     match_d = '0;
                  end
               end
               ST_SLIP: begin
                  slip_cnt_d = slip_cnt_q + 3'd1;
                  settle_d   = '0;
                  state_d    = ST_WAIT;
               end
               ST_WAIT: begin
                  if (settle_q == SETTLE_LAST) begin
                     state_d = ST_CHECK;
                     match_d = '0;
                  end else begin
                     settle_d = settle_q + 4'd1;
                  end
               end
               ST_LOCKED: begin
`ifdef LOCK_MONITOR_EN
                  // match_d counts consecutive mismatches while locked.
                  if (train && !hit) begin
                     if (match_q == MISS_LAST) begin
                        state_d    = ST_CHECK;
                        lock_d     = 1'b0;
                        slip_cnt_d = '0;
                        match_d    = '0;
                     end else begin
                        match_d = match_q + 4'd1;
                     end
                  end else begin
                     match_d = '0;
                  end
`endif
               end
               ST_FAIL: ;
               default: state_d = ST_IDLE;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q    <= ST_IDLE;
            match_q    <= '0;
            slip_cnt_q <= '0;
            settle_q   <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
         end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            slip_cnt_q <= slip_cnt_d;
            settle_q   <= settle_d;
            slip_q     <= slip_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
         end
      end

      assign bitslip[c]   = slip_q;
      assign locked[c]    = lock_q;
      assign align_err[c] = err_q;
      assign lock_nx[c]   = lock_d;
      assign err_nx[c]    = err_d;
   end

   // Summary flags use next-state values so they switch in the same cycle as locked.
   always_ff @(posedge clk) begin
      if (rst) begin
         align_done <= 1'b0;
         data_valid <= 1'b0;
         data_out   <= '0;
      end else begin
         align_done <= &(lock_nx | err_nx);
         data_valid <= &lock_nx;
         data_out   <= data_in;
      end
   end

endmodule
